// File: rtl/phase_accumulator_if.sv
// Phase accumulator to waveform ROM address bus: phase address with valid/ready
// handshake plus the end-of-period strobe.
interface phase_accumulator_if #(
  parameter int ADDR_W = 10
);
  logic [ADDR_W-1:0] addr_out;
  logic              addr_valid;
  logic              addr_ready;
  logic              wrap_pulse;

  modport master (
    output addr_out,
    output addr_valid,
    output wrap_pulse,
    input  addr_ready
  );

  modport slave (
    input  addr_out,
    input  addr_valid,
    input  wrap_pulse,
    output addr_ready
  );
endinterface

// File: rtl/phase_accumulator.sv
// DDS-style phase accumulator feeding a waveform ROM through a valid/ready bus.
// Optional completed-period counter (cycle_count) built only when WRAP_COUNTER_EN is defined.
module phase_accumulator #(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [ADDR_W-1:0] phase_step,
  input  logic              sync_clr,
  output logic [ADDR_W-1:0] step_active,
  phase_accumulator_if.master rom_bus
`ifdef WRAP_COUNTER_EN
  ,
  output logic [CNT_W-1:0]  cycle_count
`endif
);

  if (ADDR_W < 2) begin : g_bad_addr_w
    $error("phase_accumulator: ADDR_W must be at least 2");
  end
  if (CNT_W < 1) begin : g_bad_cnt_w
    $error("phase_accumulator: CNT_W must be at least 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [ADDR_W-1:0] STEP_ONE = ADDR_W'(1);

  state_t            state_reg;
  logic [ADDR_W-1:0] phase_reg;
  logic [ADDR_W-1:0] step_reg;
  logic              valid_reg;
  logic              wrap_reg;
`ifdef WRAP_COUNTER_EN
  logic [CNT_W-1:0]  count_reg;
`endif

  logic [ADDR_W-1:0] step_load;
  logic [ADDR_W:0]   sum_next;
  logic              carry_next;

  // A zero increment would stall the phase forever, so it is promoted to 1.
  always_comb begin
    step_load  = (phase_step == '0) ? STEP_ONE : phase_step;
    sum_next   = {1'b0, phase_reg} + {1'b0, step_reg};
    carry_next = sum_next[ADDR_W];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      phase_reg <= '0;
      step_reg  <= STEP_ONE;
      valid_reg <= 1'b0;
      wrap_reg  <= 1'b0;
`ifdef WRAP_COUNTER_EN
      count_reg <= '0;
`endif
    end else begin
      wrap_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sync_clr) begin
            phase_reg <= '0;
            step_reg  <= step_load;
`ifdef WRAP_COUNTER_EN
            count_reg <= '0;
`endif
          end
          if (en) begin
            state_reg <= RUN;
            valid_reg <= 1'b1;
            step_reg  <= step_load;
          end
        end
        RUN: begin
          // sync_clr beats a handshake; en low freezes the phase on the exit edge.
          if (sync_clr) begin
            phase_reg <= '0;
            step_reg  <= step_load;
`ifdef WRAP_COUNTER_EN
            count_reg <= '0;
`endif
          end else if (en && rom_bus.addr_ready) begin
            phase_reg <= sum_next[ADDR_W-1:0];
            if (carry_next) begin
              wrap_reg <= 1'b1;
              step_reg <= step_load;
`ifdef WRAP_COUNTER_EN
              count_reg <= count_reg + CNT_W'(1);
`endif
            end
          end
          if (!en) begin
            state_reg <= IDLE;
            valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= IDLE;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign rom_bus.addr_out   = phase_reg;
  assign rom_bus.addr_valid = valid_reg;
  assign rom_bus.wrap_pulse = wrap_reg;
  assign step_active        = step_reg;
`ifdef WRAP_COUNTER_EN
  assign cycle_count        = count_reg;
`endif

endmodule

// File: doc/phase_accumulator.md
PHASE_ACCUMULATOR -- requirements
Module: phase_accumulator

Interface
REQ-001 Parameter ADDR_W, default 10, SHALL set the phase/ROM address width.
REQ-002 Parameter CNT_W, default 16, SHALL set the width of cycle_count.
REQ-003 Port clk  input  1  SHALL be the single system clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 Port en  input  1  SHALL be the run enable from the control logic.
REQ-006 Port phase_step  input  ADDR_W  SHALL be the requested phase increment from the frequency select stage.
REQ-007 Port sync_clr  input  1  SHALL be the synchronous phase clear.
REQ-008 Port addr_ready  input  1  SHALL indicate that the waveform ROM stage accepts addr_out this cycle.
REQ-009 Port addr_out  output  ADDR_W  SHALL be the current phase, used as the ROM address.
REQ-010 Port addr_valid  output  1  SHALL qualify addr_out.
REQ-011 Port wrap_pulse  output  1  SHALL be a one-cycle strobe indicating that a full waveform period has completed.
REQ-012 Port step_active  output  ADDR_W  SHALL be the increment currently in use.
REQ-013 Port cycle_count  output  CNT_W  SHALL be the completed-period count, present only per REQ-030.

Function
REQ-014 The FSM SHALL have two states: IDLE and RUN. addr_valid SHALL be 1 exactly when the state is RUN.
REQ-015 IDLE->RUN SHALL occur on the first edge at which en=1; step_active SHALL load from phase_step on that same edge.
REQ-016 RUN->IDLE SHALL occur on the first edge at which en=0; the phase SHALL be retained and no advance SHALL occur on that edge.
REQ-017 A handshake SHALL be addr_valid=1 and addr_ready=1 on an edge; the phase SHALL advance only on a handshake.
REQ-018 On a handshake, the next phase SHALL be (phase + step_active) mod 2^ADDR_W; the carry out of bit ADDR_W-1 SHALL define a wrap.
REQ-019 On a wrap edge: wrap_pulse SHALL be 1 for exactly the following cycle, and step_active SHALL reload from phase_step.
REQ-020 Changes on phase_step SHALL take effect only at IDLE->RUN, at a wrap, or at sync_clr. Mid-period increments SHALL be unchanged (glitch-free frequency switch).
REQ-021 A phase_step of 0 SHALL be loaded into step_active as 1.
REQ-022 When addr_valid=1 and addr_ready=0, addr_out SHALL hold and addr_valid SHALL stay 1.
REQ-023 sync_clr=1 on an edge SHALL have priority over a handshake. It SHALL:
  - set the phase to 0;
  - reload step_active from phase_step;
  - produce no wrap_pulse;
  - leave the state unchanged.
  When en is low at the same time, both sync_clr and REQ-016 SHALL apply.
REQ-024 Latency: addr_out SHALL reflect an advance in the cycle after the handshake edge, and wrap_pulse SHALL assert in the cycle after the wrap edge.

Reset
REQ-025 rst_n=0 SHALL immediately force the following, independent of clk:
  - state = IDLE;
  - addr_out = 0;
  - addr_valid = 0;
  - wrap_pulse = 0;
  - step_active = 1;
  - cycle_count = 0.
REQ-026 A reset asserted mid-RUN SHALL discard the phase. After release, the block SHALL restart from phase 0 on the next en=1.
REQ-027 Reset release SHALL cause no output activity until en=1 is sampled.

Configuration
REQ-028 Macro WRAP_COUNTER_EN SHALL gate the cycle_count feature.
REQ-029 With WRAP_COUNTER_EN defined, cycle_count SHALL increment by 1 on each wrap edge, wrapping modulo 2^CNT_W, and SHALL clear on sync_clr.
REQ-030 Without WRAP_COUNTER_EN, the cycle_count port and its counter SHALL be absent. All other behaviour SHALL be identical.

Verification
REQ-031 Reset, en=1, phase_step=1, addr_ready=1 -> addr_out goes 0,1,...,1023,0; wrap_pulse is high for one cycle, the cycle after 1023->0.
REQ-032 phase_step=4, addr_ready=1 -> addr_out goes 0,4,...,1020,0; wrap_pulse occurs every 256 handshakes.
REQ-033 phase_step changes from 1 to 2 at addr_out=100 -> the increment stays 1 through 1023; the post-wrap sequence is 0,2,4; step_active=2 after the wrap.
REQ-034 addr_ready=0 for 5 cycles at addr_out=37 -> addr_out holds 37 and addr_valid stays 1; after addr_ready returns, the next addr_out is 38.
REQ-035 sync_clr=1 together with a handshake at addr_out=500 -> next addr_out is 0, there is no wrap_pulse, and cycle_count clears.
REQ-036 rst_n=0 mid-RUN at addr_out=700 -> all outputs go to reset values before the next clk edge; after release with en=1, addr_out restarts at 0.
